freq_meter: RTL and testbench

Gated edge-counting frequency meter: counts rising edges of an asynchronous input over a fixed window of `clk` cycles and presents the result with a one-cycle valid strobe. It is the measuring counterpart to the free-running clock divider. The divider produces clocks and strobes; this block reads a clock or strobe back and reports its rate, for self-check and display logic on the board. It supports single-shot and continuous operation.

---
 rtl/freq_meter_pkg.sv | 19 +
 rtl/freq_meter_sync_edge.sv | 34 +++
 rtl/freq_meter.sv | 129 ++++++++++++
 tb/tb_freq_meter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the gated edge-counting frequency meter.
// Consumers: freq_meter (top). Optional feature macro: FREQ_METER_OVF_EN.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } fm_state_e;

    localparam int unsigned DEF_GATE_CYCLES = 100000000;
    localparam int unsigned DEF_CNT_W       = 32;

    function automatic logic fm_is_busy(input fm_state_e s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/freq_meter_sync_edge.sv
// sync_edge: 2-FF synchronizer for an asynchronous input plus a delay register
// producing a one-cycle rising-edge strobe. Synchronous active-high reset to 0.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic edge_stb
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    always_comb begin
        s1_d = sig_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign edge_stb = s2_q & ~s3_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts rising edges of sig_in over GATE_CYCLES clk cycles.
// Define FREQ_METER_OVF_EN for a saturating counter and the ovf output.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] count
`ifdef FREQ_METER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int GATE_W = $clog2(GATE_CYCLES + 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c,
                                                  input logic             inc);
`ifdef FREQ_METER_OVF_EN
        if (inc && (c != {CNT_W{1'b1}})) return c + CNT_W'(1);
        return c;
`else
        return c + CNT_W'(inc);
`endif
    endfunction

    logic edge_stb;

    sync_edge u_sync_edge (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig_in),
        .edge_stb (edge_stb)
    );

    fm_state_e         state_q, state_d;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              valid_q, valid_d;
`ifdef FREQ_METER_OVF_EN
    logic              ovf_acc_q, ovf_acc_d;
    logic              ovf_q, ovf_d;
`endif

    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        edge_cnt_d = edge_cnt_q;
        count_d    = count_q;
        valid_d    = 1'b0;
`ifdef FREQ_METER_OVF_EN
        ovf_acc_d  = ovf_acc_q;
        ovf_d      = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) state_d = ARM;
            end
            ARM: begin
                gate_d     = '0;
                edge_cnt_d = '0;
`ifdef FREQ_METER_OVF_EN
                ovf_acc_d  = 1'b0;
`endif
                state_d    = MEASURE;
            end
            MEASURE: begin
                edge_cnt_d = cnt_step(edge_cnt_q, edge_stb);
`ifdef FREQ_METER_OVF_EN
                // An edge seen while already pinned at full scale marks the result as clipped.
                if (edge_stb && (edge_cnt_q == {CNT_W{1'b1}})) ovf_acc_d = 1'b1;
`endif
                gate_d = gate_q + GATE_W'(1);
                if (gate_q == GATE_LAST) state_d = DONE;
            end
            DONE: begin
                count_d = edge_cnt_q;
                valid_d = 1'b1;
`ifdef FREQ_METER_OVF_EN
                ovf_d   = ovf_acc_q;
`endif
                state_d = cont ? ARM : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gate_q     <= '0;
            edge_cnt_q <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
`ifdef FREQ_METER_OVF_EN
            ovf_acc_q  <= 1'b0;
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            edge_cnt_q <= edge_cnt_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
`ifdef FREQ_METER_OVF_EN
            ovf_acc_q  <= ovf_acc_d;
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign busy  = fm_is_busy(state_q);
    assign valid = valid_q;
    assign count = count_q;
`ifdef FREQ_METER_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (G=100/W=4 and G=20/W=8) share stimulus and
// are compared every cycle against a window-sum reference model. Honors FREQ_METER_OVF_EN.
module tb_freq_meter;

    localparam int GA = 100;
    localparam int WA = 4;
    localparam int GB = 20;
    localparam int WB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig_in = 1'b0;
    logic start = 1'b0;
    logic cont = 1'b0;

    logic          busy_a, valid_a, busy_b, valid_b;
    logic [WA-1:0] count_a;
    logic [WB-1:0] count_b;
`ifdef FREQ_METER_OVF_EN
    logic          ovf_a, ovf_b;
`endif

    freq_meter #(.GATE_CYCLES(GA), .CNT_W(WA)) u_a (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
        .busy(busy_a), .valid(valid_a), .count(count_a)
`ifdef FREQ_METER_OVF_EN
        , .ovf(ovf_a)
`endif
    );

    freq_meter #(.GATE_CYCLES(GB), .CNT_W(WB)) u_b (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
        .busy(busy_b), .valid(valid_b), .count(count_b)
`ifdef FREQ_METER_OVF_EN
        , .ovf(ovf_b)
`endif
    );

    always #5 clk = ~clk;

    int errs = 0;
    int chks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: samp[n] is sig_in as seen at posedge n. The strobe counted at
    // posedge m reflects the input two and three posedges earlier. A measurement
    // accepted at posedge ws sums the strobes of posedges ws+2 .. ws+G+1 and reports
    // after posedge ws+G+2.
    bit samp [0:32767];
    int cyc = 0;
    bit mdl_ok = 0;
    int gm [2] = '{GA, GB};
    int wm [2] = '{WA, WB};
    bit m_act [2];
    int m_ws [2];
    int m_cnt [2];
    bit m_val [2];
    bit m_busy [2];
    bit m_ovf [2];

    function automatic int strobe_at(input int m);
        if (m < 3) return 0;
        return (samp[m-2] && !samp[m-3]) ? 1 : 0;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            samp[cyc] = sig_in;
            if (rst) begin
                samp[cyc] = 0;
                if (cyc >= 1) samp[cyc-1] = 0;
                if (cyc >= 2) samp[cyc-2] = 0;
                for (int i = 0; i < 2; i++) begin
                    m_act[i] = 0; m_val[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_busy[i] = 0;
                end
                mdl_ok = 1;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    m_val[i] = 0;
                    if (m_act[i] && cyc == m_ws[i] + gm[i] + 2) begin
                        int sum;
                        int maxv;
                        sum = 0;
                        for (int m = m_ws[i] + 2; m <= m_ws[i] + gm[i] + 1; m++) sum += strobe_at(m);
                        maxv = (1 << wm[i]) - 1;
`ifdef FREQ_METER_OVF_EN
                        m_cnt[i] = (sum > maxv) ? maxv : sum;
                        m_ovf[i] = (sum > maxv);
`else
                        m_cnt[i] = sum % (maxv + 1);
`endif
                        m_val[i] = 1;
                        if (cont) m_ws[i] = cyc;
                        else m_act[i] = 0;
                    end else if (!m_act[i] && start) begin
                        m_act[i] = 1;
                        m_ws[i] = cyc;
                    end
                    m_busy[i] = m_act[i];
                end
            end
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mdl_ok) begin
                check("a_busy",  busy_a,  m_busy[0]);
                check("a_valid", valid_a, m_val[0]);
                check("a_count", count_a, m_cnt[0]);
                check("b_busy",  busy_b,  m_busy[1]);
                check("b_valid", valid_b, m_val[1]);
                check("b_count", count_b, m_cnt[1]);
`ifdef FREQ_METER_OVF_EN
                check("a_ovf", ovf_a, m_ovf[0]);
                check("b_ovf", ovf_b, m_ovf[1]);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nval;
        int prev;
        bit found;
        int hold;

        rst = 1'b1;
        repeat (3) tick();
        check("rst_busy_a",  busy_a,  0);
        check("rst_valid_a", valid_a, 0);
        check("rst_count_a", count_a, 0);
        check("rst_busy_b",  busy_b,  0);
        rst = 1'b0;
        tick();

        // Seven edges, four cycles apart, well inside the 100-cycle window.
        start = 1'b1; tick(); start = 1'b0;
        found = 0;
        for (int k = 1; k <= 200; k++) begin
            sig_in = (k >= 10 && k < 38 && ((k - 10) % 4) < 2);
            tick();
            if (valid_a) begin
                check("t1_latency", k, 102);
                check("t1_count", count_a, 7);
                check("t1_busy_low", busy_a, 0);
                found = 1;
                break;
            end
        end
        if (!found) check("t1_valid_seen", 0, 1);
        sig_in = 1'b0;
        repeat (5) tick();

        // Input held high across the window: no rising edge, one result of zero.
        sig_in = 1'b1;
        repeat (5) tick();
        start = 1'b1; tick(); start = 1'b0;
        nval = 0;
        for (int k = 1; k <= 130; k++) begin
            tick();
            if (valid_a) begin
                nval++;
                check("t2_count", count_a, 0);
            end
        end
        check("t2_nvalid", nval, 1);
        sig_in = 1'b0;
        repeat (5) tick();

        // start kept high while busy in single-shot mode: exactly one result.
        nval = 0;
        for (int k = 0; k < 150; k++) begin
            start = (k == 0) || busy_a;
            tick();
            if (valid_a) nval++;
        end
        start = 1'b0;
        check("t3_nvalid", nval, 1);
        check("t3_idle", busy_a, 0);

        // Continuous mode on the G=20 instance with a period-4 input.
        cont = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        prev = -1;
        nval = 0;
        for (int k = 1; k <= 130; k++) begin
            sig_in = (k % 4) < 2;
            tick();
            if (valid_b) begin
                if (prev >= 0) check("t4_period", k - prev, 22);
                check("t4_count_range", (count_b == 5 || count_b == 6), 1);
                prev = k;
                nval++;
            end
        end
        check("t4_nvalid_ge5", nval >= 5, 1);
        cont = 1'b0;
        sig_in = 1'b0;
        repeat (120) tick();
        check("t4_idle_b", busy_b, 0);
        check("t4_idle_a", busy_a, 0);

        // Reset in the middle of a measurement, then a clean measurement.
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            sig_in = (k % 4) < 2;
            tick();
        end
        rst = 1'b1; tick(); rst = 1'b0;
        check("t5_busy",  busy_a,  0);
        check("t5_count", count_a, 0);
        check("t5_valid", valid_a, 0);
        sig_in = 1'b0;
        nval = 0;
        repeat (10) begin
            tick();
            if (valid_a) nval++;
        end
        check("t5_no_valid", nval, 0);
        start = 1'b1; tick(); start = 1'b0;
        found = 0;
        for (int k = 1; k <= 200; k++) begin
            sig_in = (k >= 10 && k < 22 && ((k - 10) % 4) < 2);
            tick();
            if (valid_a) begin
                check("t5_count_after", count_a, 3);
                found = 1;
                break;
            end
        end
        if (!found) check("t5_valid_seen", 0, 1);
        sig_in = 1'b0;
        repeat (5) tick();

        // Twenty edges into the 4-bit instance: wrap or saturate.
        start = 1'b1; tick(); start = 1'b0;
        found = 0;
        for (int k = 1; k <= 200; k++) begin
            sig_in = (k >= 5 && k < 85 && ((k - 5) % 4) < 2);
            tick();
            if (valid_a) begin
`ifdef FREQ_METER_OVF_EN
                check("t6_count_sat", count_a, 15);
                check("t6_ovf", ovf_a, 1);
`else
                check("t6_count_wrap", count_a, 4);
`endif
                found = 1;
                break;
            end
        end
        if (!found) check("t6_valid_seen", 0, 1);
        sig_in = 1'b0;
        repeat (5) tick();

        // Randomized traffic; input pulses stay at least two cycles high and low.
        hold = 2;
        for (int k = 0; k < 4000; k++) begin
            if (hold == 0) begin
                sig_in = ~sig_in;
                hold = $urandom_range(2, 6);
            end
            hold--;
            start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) cont = ~cont;
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        start = 1'b0;
        cont = 1'b0;
        repeat (130) tick();
        check("end_idle_a", busy_a, 0);
        check("end_idle_b", busy_b, 0);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
